// File: rtl/accum_counter_bank.sv
// Purpose : bank of N independent accumulating counters with sticky per-channel overflow flags.
// Latency : counter update 1 cycle after io_inc; io_tot is registered (shows cnt 1 cycle later).
// Backpr. : none; every cycle accepts one increment and one clear.
//
// Ports:
//   clk, reset (async, active-low)
//   io_inc/io_ch/io_amt       : add io_amt to channel io_ch (io_ch >= N ignored)
//   io_clr/io_clr_ch          : zero one channel (io_clr_ch >= N ignored); clear beats increment
//   io_ovf_clr                : per-channel mask clearing sticky flags; a new overflow beats it
//   io_rd_ch/io_tot           : registered read of the pre-update count (0 if io_rd_ch >= N)
//   io_ovf                    : sticky overflow flags
// Optional macro ACCUM_COUNTER_BANK_THRESH_EN adds io_thresh (in), io_hit and io_hit_ch (out):
//   a one-cycle pulse when an increment moves a channel from below io_thresh to at/above it.
module accum_counter_bank #(
    parameter int W        = 8,
    parameter int AW       = 4,
    parameter int N        = 4,
    parameter int OVF_MODE = 0,
    localparam int CHW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           io_inc,
    input  logic [CHW-1:0] io_ch,
    input  logic [AW-1:0]  io_amt,
    input  logic           io_clr,
    input  logic [CHW-1:0] io_clr_ch,
    input  logic [N-1:0]   io_ovf_clr,
    input  logic [CHW-1:0] io_rd_ch,
    output logic [W-1:0]   io_tot,
    output logic [N-1:0]   io_ovf
`ifdef ACCUM_COUNTER_BANK_THRESH_EN
    ,
    input  logic [W-1:0]   io_thresh,
    output logic           io_hit,
    output logic [CHW-1:0] io_hit_ch
`endif
);

    // Channel count in index width + 1 so that range checks never truncate N.
    localparam logic [CHW:0] N_LIM = N[CHW:0];

    logic [W-1:0]  r_cnt [N];
    logic [N-1:0]  r_ovf;
    logic [W-1:0]  r_tot;

    logic          w_inc_ok;
    logic          w_clr_ok;
    logic          w_inc_eff;
    logic [W-1:0]  w_cur;
    logic [W:0]    w_sum;
    logic          w_ovf;
    logic [W-1:0]  w_new;
    logic [W-1:0]  w_rd_val;

    assign w_inc_ok  = io_inc && ({1'b0, io_ch} < N_LIM);
    assign w_clr_ok  = io_clr && ({1'b0, io_clr_ch} < N_LIM);
    // A clear on the same channel swallows the increment entirely, including its overflow.
    assign w_inc_eff = w_inc_ok && !(w_clr_ok && (io_clr_ch == io_ch));

    always_comb begin
        w_cur = '0;
        if ({1'b0, io_ch} < N_LIM) begin
            w_cur = r_cnt[io_ch];
        end
    end

    always_comb begin
        w_rd_val = '0;
        if ({1'b0, io_rd_ch} < N_LIM) begin
            w_rd_val = r_cnt[io_rd_ch];
        end
    end

    assign w_sum = {1'b0, w_cur} + {{(W + 1 - AW){1'b0}}, io_amt};
    assign w_ovf = w_sum[W];

    always_comb begin
        w_new = w_sum[W-1:0];
        if (w_ovf) begin
            case (OVF_MODE)
                0:       w_new = '0;
                1:       w_new = '1;
                default: w_new = w_sum[W-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf <= '0;
            r_tot <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_clr_ok && (io_clr_ch == CHW'(i))) begin
                    r_cnt[i] <= '0;
                end else if (w_inc_eff && (io_ch == CHW'(i))) begin
                    r_cnt[i] <= w_new;
                end
                // Setting a flag takes priority over clearing it in the same cycle.
                r_ovf[i] <= (r_ovf[i] & ~io_ovf_clr[i]) |
                            (w_inc_eff && w_ovf && (io_ch == CHW'(i)));
            end
            r_tot <= w_rd_val;
        end
    end

    assign io_tot = r_tot;
    assign io_ovf = r_ovf;

`ifdef ACCUM_COUNTER_BANK_THRESH_EN
    localparam bit SAT_MODE = (OVF_MODE == 1);

    logic           r_hit;
    logic [CHW-1:0] r_hit_ch;
    logic           w_hit;

    // Wrapped or reset-to-zero results are not real crossings; saturation still counts.
    // io_thresh == 0 can never hit because w_cur < 0 is impossible.
    assign w_hit = w_inc_eff && (w_cur < io_thresh) && (w_new >= io_thresh) &&
                   !(w_ovf && !SAT_MODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit    <= 1'b0;
            r_hit_ch <= '0;
        end else begin
            r_hit <= w_hit;
            if (w_hit) begin
                r_hit_ch <= io_ch;
            end
        end
    end

    assign io_hit    = r_hit;
    assign io_hit_ch = r_hit_ch;
`endif

endmodule

// File: tb/tb_accum_counter_bank.sv
// Purpose : directed checks of accum_counter_bank in legacy, saturate, modulo and N=3 builds.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : not applicable; stimulus drives one operation set per cycle.
module tb_accum_counter_bank;

    logic       clk;
    logic       reset;
    logic       io_inc;
    logic [1:0] io_ch;
    logic [3:0] io_amt;
    logic       io_clr;
    logic [1:0] io_clr_ch;
    logic [3:0] io_ovf_clr;
    logic [1:0] io_rd_ch;

    logic [7:0] tot0, tot1, tot2, tot3;
    logic [3:0] ovf0, ovf1, ovf2;
    logic [2:0] ovf3;

    int n_chk;
    int n_fail;

`ifdef ACCUM_COUNTER_BANK_THRESH_EN
    logic [7:0] io_thresh;
    logic       hit0, hit1, hit2, hit3;
    logic [1:0] hch0, hch1, hch2, hch3;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    accum_counter_bank #(.W(8), .AW(4), .N(4), .OVF_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .io_inc(io_inc), .io_ch(io_ch), .io_amt(io_amt),
        .io_clr(io_clr), .io_clr_ch(io_clr_ch), .io_ovf_clr(io_ovf_clr),
        .io_rd_ch(io_rd_ch), .io_tot(tot0), .io_ovf(ovf0)
`ifdef ACCUM_COUNTER_BANK_THRESH_EN
        , .io_thresh(io_thresh), .io_hit(hit0), .io_hit_ch(hch0)
`endif
    );

    accum_counter_bank #(.W(8), .AW(4), .N(4), .OVF_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .io_inc(io_inc), .io_ch(io_ch), .io_amt(io_amt),
        .io_clr(io_clr), .io_clr_ch(io_clr_ch), .io_ovf_clr(io_ovf_clr),
        .io_rd_ch(io_rd_ch), .io_tot(tot1), .io_ovf(ovf1)
`ifdef ACCUM_COUNTER_BANK_THRESH_EN
        , .io_thresh(io_thresh), .io_hit(hit1), .io_hit_ch(hch1)
`endif
    );

    accum_counter_bank #(.W(8), .AW(4), .N(4), .OVF_MODE(2)) dut2 (
        .clk(clk), .reset(reset), .io_inc(io_inc), .io_ch(io_ch), .io_amt(io_amt),
        .io_clr(io_clr), .io_clr_ch(io_clr_ch), .io_ovf_clr(io_ovf_clr),
        .io_rd_ch(io_rd_ch), .io_tot(tot2), .io_ovf(ovf2)
`ifdef ACCUM_COUNTER_BANK_THRESH_EN
        , .io_thresh(io_thresh), .io_hit(hit2), .io_hit_ch(hch2)
`endif
    );

    accum_counter_bank #(.W(8), .AW(4), .N(3), .OVF_MODE(0)) dut3 (
        .clk(clk), .reset(reset), .io_inc(io_inc), .io_ch(io_ch), .io_amt(io_amt),
        .io_clr(io_clr), .io_clr_ch(io_clr_ch), .io_ovf_clr(io_ovf_clr[2:0]),
        .io_rd_ch(io_rd_ch), .io_tot(tot3), .io_ovf(ovf3)
`ifdef ACCUM_COUNTER_BANK_THRESH_EN
        , .io_thresh(io_thresh), .io_hit(hit3), .io_hit_ch(hch3)
`endif
    );

    typedef struct {
        logic       inc;
        logic [1:0] ch;
        logic [3:0] amt;
        logic       clr;
        logic [1:0] clr_ch;
        logic [3:0] ovf_clr;
        logic [1:0] rd;
        logic [7:0] exp_tot;
        logic [3:0] exp_ovf;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the edge with strobes dropped.
    task automatic cyc(input logic inc, input logic [1:0] ch, input logic [3:0] amt,
                       input logic clr, input logic [1:0] clr_ch, input logic [3:0] oclr,
                       input logic [1:0] rd);
        io_inc     = inc;
        io_ch      = ch;
        io_amt     = amt;
        io_clr     = clr;
        io_clr_ch  = clr_ch;
        io_ovf_clr = oclr;
        io_rd_ch   = rd;
        @(posedge clk);
        #1;
        io_inc     = 1'b0;
        io_clr     = 1'b0;
        io_ovf_clr = 4'h0;
    endtask

    task automatic add(input logic [1:0] ch, input logic [3:0] amt);
        cyc(1'b1, ch, amt, 1'b0, 2'd0, 4'h0, io_rd_ch);
    endtask

    task automatic idle(input logic [1:0] rd);
        cyc(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'h0, rd);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        io_inc     = 1'b0;
        io_ch      = 2'd0;
        io_amt     = 4'd0;
        io_clr     = 1'b0;
        io_clr_ch  = 2'd0;
        io_ovf_clr = 4'h0;
        io_rd_ch   = 2'd0;
`ifdef ACCUM_COUNTER_BANK_THRESH_EN
        io_thresh  = 8'd0;
`endif
        reset      = 1'b0;

        //            inc   ch    amt   clr   clr_ch oclr  rd    tot      ovf
        tbl[0]  = '{1'b1, 2'd1, 4'd5, 1'b0, 2'd0, 4'h0, 2'd1, 8'd250, 4'b0000};
        tbl[1]  = '{1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'h0, 2'd1, 8'd255, 4'b0000};
        tbl[2]  = '{1'b1, 2'd1, 4'd0, 1'b0, 2'd0, 4'h0, 2'd1, 8'd255, 4'b0000};
        tbl[3]  = '{1'b1, 2'd1, 4'd1, 1'b0, 2'd0, 4'h0, 2'd1, 8'd255, 4'b0010};
        tbl[4]  = '{1'b0, 2'd0, 4'd0, 1'b1, 2'd1, 4'h0, 2'd1, 8'd0,   4'b0010};
        tbl[5]  = '{1'b1, 2'd3, 4'd4, 1'b1, 2'd3, 4'h0, 2'd3, 8'd10,  4'b0010};
        tbl[6]  = '{1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'h0, 2'd3, 8'd0,   4'b0010};
        tbl[7]  = '{1'b1, 2'd2, 4'd3, 1'b0, 2'd0, 4'h0, 2'd2, 8'd0,   4'b0010};
        tbl[8]  = '{1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'h0, 2'd2, 8'd3,   4'b0010};
        tbl[9]  = '{1'b1, 2'd0, 4'd7, 1'b1, 2'd2, 4'h0, 2'd2, 8'd3,   4'b0010};
        tbl[10] = '{1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'h2, 2'd0, 8'd7,   4'b0000};
        tbl[11] = '{1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'h0, 2'd2, 8'd0,   4'b0000};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2'd0);
        chk("reset_tot", 32'(tot0), 32'd0);
        chk("reset_ovf", 32'(ovf0), 32'd0);

        // Overflow modes: ch0 to 250, then +15.
        for (int i = 0; i < 16; i++) add(2'd0, 4'd15);
        add(2'd0, 4'd10);
        idle(2'd0);
        chk("pre_ovf_tot", 32'(tot1), 32'd250);
        add(2'd0, 4'd15);
        idle(2'd0);
        chk("mode0_wrap_zero", 32'(tot0), 32'd0);
        chk("mode1_saturate", 32'(tot1), 32'd255);
        chk("mode2_modulo", 32'(tot2), 32'd9);
        chk("mode0_ovf", 32'(ovf0), 32'b0001);
        chk("mode1_ovf", 32'(ovf1), 32'b0001);
        chk("mode2_ovf", 32'(ovf2), 32'b0001);
        chk("n3_ovf", 32'(ovf3), 32'b001);
        cyc(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'h1, 2'd0);
        chk("ovf_clr", 32'(ovf1), 32'd0);
        add(2'd0, 4'd1);
        chk("sat_reflag", 32'(ovf1), 32'b0001);
        chk("mod_no_reflag", 32'(ovf2), 32'd0);
        cyc(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'h1, 2'd0);
        cyc(1'b1, 2'd0, 4'd0, 1'b0, 2'd0, 4'h0, 2'd0);
        chk("sat_amt0_noflag", 32'(ovf1), 32'd0);
        chk("sat_amt0_tot", 32'(tot1), 32'd255);
        add(2'd0, 4'd1);

        // Mid-run asynchronous reset with ch2 = 37.
        add(2'd2, 4'd15);
        add(2'd2, 4'd15);
        add(2'd2, 4'd7);
        idle(2'd2);
        chk("ch2_37", 32'(tot0), 32'd37);
        chk("pre_reset_ovf", 32'(ovf1), 32'b0001);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_tot", 32'(tot0), 32'd0);
        chk("async_rst_ovf", 32'(ovf1), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(2'd2);
        idle(2'd2);
        chk("post_rst_cnt2", 32'(tot0), 32'd0);
        chk("post_rst_ovf", 32'(ovf1), 32'd0);

`ifdef ACCUM_COUNTER_BANK_THRESH_EN
        io_thresh = 8'd20;
        add(2'd0, 4'd15);
        chk("thr_below", 32'(hit0), 32'd0);
        add(2'd0, 4'd3);
        chk("thr_18", 32'(hit0), 32'd0);
        add(2'd0, 4'd2);
        chk("thr_hit", 32'(hit0), 32'd1);
        chk("thr_hit_ch", 32'(hch0), 32'd0);
        idle(2'd0);
        chk("thr_pulse_end", 32'(hit0), 32'd0);
        add(2'd0, 4'd2);
        chk("thr_no_rehit", 32'(hit0), 32'd0);
        add(2'd2, 4'd15);
        add(2'd2, 4'd15);
        chk("thr_hit_ch2", 32'(hit0), 32'd1);
        chk("thr_hit_ch2_id", 32'(hch0), 32'd2);
        io_thresh = 8'd0;
        do_reset();
`endif

        // Table phase: ch1 = 250, ch3 = 10.
        for (int i = 0; i < 16; i++) add(2'd1, 4'd15);
        add(2'd1, 4'd10);
        add(2'd3, 4'd10);
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].inc, tbl[i].ch, tbl[i].amt, tbl[i].clr, tbl[i].clr_ch,
                tbl[i].ovf_clr, tbl[i].rd);
            chk($sformatf("tbl%0d_tot", i), 32'(tot0), 32'(tbl[i].exp_tot));
            chk($sformatf("tbl%0d_ovf", i), 32'(ovf0), 32'(tbl[i].exp_ovf));
        end

        // Overflow set beats concurrent flag clear on ch3; N=3 bank ignores ch3.
        for (int i = 0; i < 17; i++) add(2'd3, 4'd15);
        idle(2'd3);
        chk("ch3_255", 32'(tot0), 32'd255);
        chk("n3_rd_oor", 32'(tot3), 32'd0);
        cyc(1'b1, 2'd3, 4'd1, 1'b0, 2'd0, 4'h8, 2'd3);
        chk("set_beats_clr", 32'(ovf0), 32'b1000);
        chk("n3_ch3_ignored", 32'(ovf3), 32'd0);
        cyc(1'b0, 2'd0, 4'd0, 1'b0, 2'd0, 4'h8, 2'd3);
        chk("ovf3_cleared", 32'(ovf0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=%0d required=%0d", 0, 1);
        $fatal(1);
    end

endmodule
